// File: rtl/blake2_msg_packer.sv
// blake2_msg_packer: packs a little-endian message byte stream into 16-word
// blocks for the blake2 compression core, zero-pads the final block, tracks
// the running byte count and holds off input while the core is busy.
module blake2_msg_packer #(
   parameter int W     = 64,
   parameter int BB    = W * 2,
   parameter int LEN_W = $clog2(W / 8) + 1
) (
   input  logic              clk,
   input  logic              nreset,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [W-1:0]      in_data_i,
   input  logic [LEN_W-1:0]  in_len_i,
   input  logic              in_last_i,
   output logic              blk_valid_o,
   output logic [W*16-1:0]   blk_data_o,
   output logic              blk_first_o,
   output logic              blk_last_o,
   output logic [63:0]       blk_ll_o,
   input  logic              hash_done_i
);

   localparam int NB    = W / 8;
   localparam int WORDS = BB / NB;
   localparam int IDX_W = $clog2(WORDS);
   localparam logic [LEN_W-1:0] NB_LEN   = LEN_W'(NB);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   typedef enum logic [1:0] {FILL, SEND, WAIT} state_t;

   state_t            state;
   state_t            next_state;
   logic [IDX_W-1:0]  idx;
   logic [63:0]       byte_cnt;
   logic              first_flag;
   logic [W*16-1:0]   buffer;
   logic [W*16-1:0]   merged;
   logic              accept;
   logic              closing;
   logic [LEN_W-1:0]  beat_len;
   logic [W-1:0]      beat_word;
   logic [63:0]       beat_bytes;
   logic [63:0]       cnt_sum;

   // Oversized lengths are treated as a full beat.
   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
      return (len > NB_LEN) ? NB_LEN : len;
   endfunction

   // Keep the first len bytes of a beat and zero everything above them.
   function automatic logic [W-1:0] mask_beat(input logic [W-1:0] data,
                                              input logic [LEN_W-1:0] len);
      logic [W-1:0] m;
      m = '0;
      for (int b = 0; b < NB; b++) begin
         if (b < int'(len)) m[8*b +: 8] = data[8*b +: 8];
      end
      return m;
   endfunction

   assign accept     = in_valid_i & in_ready_o & (state == FILL);
   assign closing    = accept & (in_last_i | (idx == LAST_IDX));
   assign beat_len   = clamp_len(in_len_i);
   assign beat_word  = in_last_i ? mask_beat(in_data_i, beat_len) : in_data_i;
   assign beat_bytes = in_last_i ? 64'(beat_len) : 64'(NB);
   assign cnt_sum    = byte_cnt + beat_bytes;

   // Current buffer with the incoming beat dropped into its word slot.
   always_comb begin
      merged = buffer;
      merged[idx*W +: W] = beat_word;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) state <= FILL;
      else         state <= next_state;
   end

   // Next-state logic and the one-cycle block strobe.
   always_comb begin
      next_state  = state;
      blk_valid_o = 1'b0;
      case (state)
         FILL: if (closing) next_state = SEND;
         SEND: begin
            blk_valid_o = 1'b1;
            next_state  = WAIT;
         end
         WAIT: if (hash_done_i) next_state = FILL;
         default: next_state = FILL;
      endcase
   end

   // Block assembly, byte counting, presented-block registers and ready.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         in_ready_o  <= 1'b0;
         idx         <= '0;
         byte_cnt    <= '0;
         first_flag  <= 1'b1;
         buffer      <= '0;
         blk_data_o  <= '0;
         blk_first_o <= 1'b0;
         blk_last_o  <= 1'b0;
         blk_ll_o    <= '0;
      end else begin
         in_ready_o <= (next_state == FILL);
         case (state)
            FILL: begin
               if (accept) begin
                  buffer   <= merged;
                  idx      <= idx + 1'b1;
                  byte_cnt <= cnt_sum;
                  if (closing) begin
                     blk_data_o  <= merged;
                     blk_first_o <= first_flag;
                     blk_last_o  <= in_last_i;
                     blk_ll_o    <= cnt_sum;
                  end
               end
            end
            SEND: first_flag <= 1'b0;
            WAIT: begin
               if (hash_done_i) begin
                  idx    <= '0;
                  buffer <= '0;
                  // A finished message restarts counting for the next one.
                  if (blk_last_o) begin
                     first_flag <= 1'b1;
                     byte_cnt   <= '0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/blake2_msg_packer.md
Name: blake2_msg_packer

Overview:
- Upstream stage of the blake2 compression core.
- Accepts a word-wide message byte stream, packs it into 16-word (BB-byte) little-endian blocks, zero-pads the final block, and tracks the running byte count.
- Presents each block to the core with first/last flags and the byte count, then holds off further input until the core reports completion.
- Default configuration is blake2b (W=64, 128-byte blocks).

Parameters:
- W, 64, word width in bits (64 for blake2b, 32 for blake2s).
- BB, W*2, block size in bytes (16 words of W bits).
- LEN_W, $clog2(W/8)+1, width of the byte-count field on an input beat.

Ports:
- clk  in  1  clock.
- nreset  in  1  asynchronous active-low reset.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  packer can accept a beat this cycle.
- in_data_i  in  W  message bytes; stream byte 0 of the beat is in_data_i[7:0].
- in_len_i  in  LEN_W  valid bytes in the beat (0..W/8); sampled only when in_last_i=1.
- in_last_i  in  1  final beat of the message.
- blk_valid_o  out  1  one-cycle pulse, block presented; drives the core's valid_i.
- blk_data_o  out  W*16  block; word k at [W*k+W-1 : W*k].
- blk_first_o  out  1  first block of the message.
- blk_last_o  out  1  last block of the message.
- blk_ll_o  out  64  total message bytes consumed up to and including this block.
- hash_done_i  in  1  core completion pulse (core valid_o).

Behaviour:
- Reset (asynchronous, nreset=0) clears everything:
  - state=FILL, word index=0, byte count=0, first flag=1, block buffer=0.
  - Outputs: blk_valid_o=0, blk_first_o=0, blk_last_o=0, blk_ll_o=0, blk_data_o=0, in_ready_o=0 while reset is asserted, then 1 in FILL.
- States: FILL, SEND, WAIT.
- FILL:
  - in_ready_o=1. A beat is accepted when in_valid_i & in_ready_o.
  - The beat is written to word[idx] and idx increments.
  - Non-last beats are always full (W/8 bytes); the byte count increases by W/8.
  - Last beat: bytes at and above in_len_i in the beat are written as zero; the byte count increases by in_len_i.
  - FILL -> SEND when the accepted beat fills word 15, or when in_last_i=1. Words after the last written word are zero.
- SEND:
  - in_ready_o=0. blk_valid_o=1 for exactly one cycle.
  - blk_data_o, blk_first_o, blk_last_o and blk_ll_o are registered and stable from SEND until the next SEND.
  - blk_last_o=1 iff the block was closed by in_last_i. blk_first_o = first flag.
  - SEND -> WAIT. The first flag is cleared.
- WAIT:
  - in_ready_o=0. Waits for hash_done_i=1.
  - On hash_done_i: idx=0, buffer cleared, state -> FILL.
  - If the block was last, the first flag is set again and the byte count is cleared for the next message.
- hash_done_i outside WAIT is ignored.
- Latency: the block-closing beat is accepted in cycle N; blk_valid_o is high in cycle N+1.
- Minimum gap between blocks: 1 + core latency + 1 cycles.
- Last flag on a full (16th-word) beat closes that block as last. No extra empty block is ever generated, which is the BLAKE2 rule for messages that are an exact multiple of BB.
- Empty message: in_last_i=1 with in_len_i=0 as the sole beat gives one all-zero block, first=1, last=1, ll=0.
- in_len_i=0 with in_last_i=1 at idx=0 of a non-first block is illegal; the result is undefined (assertion in bench).
- in_len_i > W/8 is illegal; it is clamped to W/8.
- Byte count wraps modulo 2^64.
- Reset asserted mid-block or in WAIT aborts the message immediately. The bench must re-present the message from its start.

Test Plan:
- Empty message: reset, one beat last=1 len=0 -> single blk_valid_o pulse with data=0, first=1, last=1, ll=0; in_ready_o low until hash_done_i.
- "abc": one beat data=0x..636261, len=3, last=1 -> word0=0x0000000000636261, words1..15=0, first=1, last=1, ll=3, blk_valid_o the cycle after acceptance.
- Exactly 128 bytes: 16 full beats, last on the 16th -> exactly one block, first=1, last=1, ll=128; no second block after hash_done_i.
- 129 bytes: block 1 gives first=1, last=0, ll=128. After hash_done_i, one beat with len=1, last=1 gives first=0, last=1, ll=129, word0=byte128 zero-extended.
- Backpressure and spurious done:
  - in_valid_i held high through WAIT -> no beat accepted until the cycle after hash_done_i.
  - hash_done_i pulsed in FILL -> ignored.
- Reset in WAIT after block 1 of a 2-block message -> outputs clear asynchronously. A new message afterwards starts with first=1, ll counted from 0.
